// File: rtl/vector_op_sequencer.sv
// Single-issue sequencer for vector_element_alu: READ, EXEC and write-back, one command in flight.
// Latency: handshake c0, rf_re c1, alu_set c2, rf_we/done c3 (alu_en prompt), cmd_ready again c4.
// Backpressure: cmd_ready only in IDLE; optional perf counters under VSEQ_PERF_CNT_EN.
module vector_op_sequencer #(
  parameter int BITS     = 8,
  parameter int REG_AW   = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_src_a,
  input  logic [REG_AW-1:0] cmd_src_b,
  input  logic              cmd_scalar_sel,
  input  logic [BITS-1:0]   cmd_scalar,
  output logic              rf_re,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  output logic [2:0]        alu_op_sel,
  output logic              alu_scalar_sel,
  output logic [BITS-1:0]   alu_scalar,
  output logic              alu_set,
  input  logic              alu_en,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_busy
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [REG_AW-1:0] src_a_q, src_a_d;
  logic [REG_AW-1:0] src_b_q, src_b_d;
  logic              scalar_sel_q, scalar_sel_d;
  logic [BITS-1:0]   scalar_q, scalar_d;
  logic              err_q, err_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]     wait_nx;

  assign wait_nx = wait_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    scalar_sel_d = scalar_sel_q;
    scalar_d     = scalar_q;
    err_d        = err_q;
    wait_cnt_d   = wait_cnt_q;
    cmd_ready    = 1'b0;
    rf_re        = 1'b0;
    alu_set      = 1'b0;
    rf_we        = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d         = cmd_op;
          dst_d        = cmd_dst;
          src_a_d      = cmd_src_a;
          src_b_d      = cmd_src_b;
          scalar_sel_d = cmd_scalar_sel;
          scalar_d     = cmd_scalar;
          err_d        = 1'b0;
          state_d      = READ;
        end
      end
      READ: begin
        rf_re   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        alu_set    = 1'b1;
        wait_cnt_d = '0;
        state_d    = WB;
      end
      WB: begin
        if (alu_en) begin
          rf_we   = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_nx;
          // Give up after WAIT_MAX idle WB cycles; nothing is written back.
          if (wait_nx == CW'(WAIT_MAX)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      dst_q        <= '0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      scalar_sel_q <= 1'b0;
      scalar_q     <= '0;
      err_q        <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      scalar_sel_q <= scalar_sel_d;
      scalar_q     <= scalar_d;
      err_q        <= err_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign err            = err_q;
  assign rf_ra_addr     = src_a_q;
  assign rf_rb_addr     = src_b_q;
  assign rf_wa          = dst_q;
  assign alu_op_sel     = op_q;
  assign alu_scalar_sel = scalar_sel_q;
  assign alu_scalar     = scalar_q;

`ifdef VSEQ_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_busy_d = perf_busy_q;
    if (done && (perf_ops_q != 32'hFFFF_FFFF)) perf_ops_d = perf_ops_q + 32'd1;
    if (busy && (perf_busy_q != 32'hFFFF_FFFF)) perf_busy_d = perf_busy_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_busy = perf_busy_q;
`else
  assign perf_ops  = 32'd0;
  assign perf_busy = 32'd0;
`endif

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Directed bench for vector_op_sequencer; checks cycle-exact strobes, timeout and reset behaviour.
module tb_vector_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op, cmd_dst, cmd_src_a, cmd_src_b;
  logic       cmd_scalar_sel;
  logic [7:0] cmd_scalar;
  logic       rf_re;
  logic [2:0] rf_ra_addr, rf_rb_addr;
  logic [2:0] alu_op_sel;
  logic       alu_scalar_sel;
  logic [7:0] alu_scalar;
  logic       alu_set, alu_en, rf_we;
  logic [2:0] rf_wa;
  logic       busy, done, err;
  logic [31:0] perf_ops, perf_busy;

  int vectors = 0;
  int errs    = 0;

`ifdef VSEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  vector_op_sequencer #(.BITS(8), .REG_AW(3), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_scalar_sel(cmd_scalar_sel), .cmd_scalar(cmd_scalar),
    .rf_re(rf_re), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .alu_op_sel(alu_op_sel), .alu_scalar_sel(alu_scalar_sel), .alu_scalar(alu_scalar),
    .alu_set(alu_set), .alu_en(alu_en), .rf_we(rf_we), .rf_wa(rf_wa),
    .busy(busy), .done(done), .err(err),
    .perf_ops(perf_ops), .perf_busy(perf_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] a,
                         input logic [2:0] b, input logic ss, input logic [7:0] sc);
    cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b;
    cmd_scalar_sel = ss; cmd_scalar = sc;
  endtask

  task automatic check_perf(input string tag, input logic [31:0] ops, input logic [31:0] bsy);
    check({tag, "_perf_ops"}, perf_ops, PERF ? ops : 32'd0);
    check({tag, "_perf_busy"}, perf_busy, PERF ? bsy : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; alu_en = 1'b0;
    set_cmd(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rf_re", rf_re, 0);
    check("rst_alu_set", alu_set, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addrs", {rf_ra_addr, rf_rb_addr, rf_wa}, 0);
    check("rst_op_scalar", {alu_op_sel, alu_scalar_sel, alu_scalar}, 0);
    check_perf("rst", 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Add, dst=2 src_a=0 src_b=1, alu_en one cycle after alu_set
    @(negedge clk); set_cmd(3'd0, 3'd2, 3'd0, 3'd1, 1'b0, 8'h00); cmd_valid = 1'b1; #1;
    check("t1_c0_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t1_c1_rf_re", rf_re, 1);
    check("t1_c1_ra", rf_ra_addr, 0);
    check("t1_c1_rb", rf_rb_addr, 1);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_ready", cmd_ready, 0);
    check("t1_c1_op", alu_op_sel, 0);
    check("t1_c1_set", alu_set, 0);
    @(negedge clk); #1;
    check("t1_c2_set", alu_set, 1);
    check("t1_c2_rf_re", rf_re, 0);
    check("t1_c2_we", rf_we, 0);
    @(negedge clk); alu_en = 1'b1; #1;
    check("t1_c3_we", rf_we, 1);
    check("t1_c3_wa", rf_wa, 2);
    check("t1_c3_done", done, 1);
    check("t1_c3_op", alu_op_sel, 0);
    check("t1_c3_set", alu_set, 0);
    @(negedge clk); alu_en = 1'b0; #1;
    check("t1_c4_ready", cmd_ready, 1);
    check("t1_c4_done", done, 0);
    check("t1_c4_we", rf_we, 0);
    check("t1_c4_busy", busy, 0);

    // Scalar multiply, op=010, scalar 05, alu_en one cycle late
    @(negedge clk); set_cmd(3'd2, 3'd5, 3'd3, 3'd4, 1'b1, 8'h05); cmd_valid = 1'b1; #1;
    check("t2_c0_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t2_c1_ssel", alu_scalar_sel, 1);
    check("t2_c1_scalar", alu_scalar, 8'h05);
    check("t2_c1_rb", rf_rb_addr, 4);
    check("t2_c1_op", alu_op_sel, 2);
    @(negedge clk); #1;
    check("t2_c2_set", alu_set, 1);
    check("t2_c2_scalar", {alu_scalar_sel, alu_scalar}, 9'h105);
    @(negedge clk); #1;
    check("t2_c3_we", rf_we, 0);
    check("t2_c3_busy", busy, 1);
    check("t2_c3_scalar", {alu_scalar_sel, alu_scalar}, 9'h105);
    @(negedge clk); alu_en = 1'b1; #1;
    check("t2_c4_we", rf_we, 1);
    check("t2_c4_wa", rf_wa, 5);
    check("t2_c4_done", done, 1);
    check("t2_c4_scalar", {alu_scalar_sel, alu_scalar}, 9'h105);
    @(negedge clk); alu_en = 1'b0; #1;
    check("t2_c5_we", rf_we, 0);
    check("t2_c5_ready", cmd_ready, 1);

    // Back-to-back with cmd_valid held high; second op is NOT (111)
    @(negedge clk); set_cmd(3'd1, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00); cmd_valid = 1'b1; alu_en = 1'b1; #1;
    check("t3_c0_ready", cmd_ready, 1);
    @(negedge clk); #1;
    check("t3_c1_rf_re", rf_re, 1);
    check("t3_c1_addrs", {rf_ra_addr, rf_rb_addr}, {3'd2, 3'd3});
    check("t3_c1_op", alu_op_sel, 1);
    @(negedge clk); #1;
    check("t3_c2_set", alu_set, 1);
    check("t3_c2_we", rf_we, 0);
    @(negedge clk); set_cmd(3'd7, 3'd7, 3'd6, 3'd6, 1'b0, 8'h00); #1;
    check("t3_c3_done", done, 1);
    check("t3_c3_wa", rf_wa, 1);
    check("t3_c3_ready", cmd_ready, 0);
    @(negedge clk); #1;
    check("t3_c4_ready", cmd_ready, 1);
    check("t3_c4_done", done, 0);
    @(negedge clk); #1;
    check("t3_c5_rf_re", rf_re, 1);
    check("t3_c5_addrs", {rf_ra_addr, rf_rb_addr}, {3'd6, 3'd6});
    check("t3_c5_op", alu_op_sel, 7);
    @(negedge clk); #1;
    check("t3_c6_set", alu_set, 1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t3_c7_done", done, 1);
    check("t3_c7_wa", rf_wa, 7);
    @(negedge clk); alu_en = 1'b0; #1;
    check("t3_c8_busy", busy, 0);
    check("t3_c8_ready", cmd_ready, 1);
    check_perf("t3", 32'd4, 32'd13);

    // Timeout: alu_en never arrives
    @(negedge clk); set_cmd(3'd3, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00); cmd_valid = 1'b1; #1;
    check("t4_c0_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t4_c1_rf_re", rf_re, 1);
    @(negedge clk); #1;
    check("t4_c2_set", alu_set, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      check($sformatf("t4_wb%0d_we", i), rf_we, 0);
      check($sformatf("t4_wb%0d_err", i), err, 0);
      check($sformatf("t4_wb%0d_busy", i), busy, 1);
    end
    @(negedge clk); #1;
    check("t4_to_err", err, 1);
    check("t4_to_ready", cmd_ready, 1);
    check("t4_to_busy", busy, 0);
    check("t4_to_we", rf_we, 0);
    @(negedge clk); #1;
    check("t4_err_sticky", err, 1);
    // Next accepted command clears err
    @(negedge clk); set_cmd(3'd0, 3'd3, 3'd3, 3'd3, 1'b0, 8'h00); cmd_valid = 1'b1; #1;
    check("t4r_c0_err", err, 1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t4r_c1_err", err, 0);
    check("t4r_c1_rf_re", rf_re, 1);
    @(negedge clk); #1;
    check("t4r_c2_set", alu_set, 1);
    @(negedge clk); alu_en = 1'b1; #1;
    check("t4r_c3_we", rf_we, 1);
    check("t4r_c3_wa", rf_wa, 3);
    @(negedge clk); alu_en = 1'b0; #1;
    check_perf("t4", 32'd5, 32'd33);

    // Reset asserted during EXEC with alu_en already high
    @(negedge clk); set_cmd(3'd4, 3'd6, 3'd5, 3'd7, 1'b1, 8'hA5); cmd_valid = 1'b1; alu_en = 1'b1; #1;
    check("t5_c0_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    check("t5_c1_rf_re", rf_re, 1);
    @(negedge clk); #1;
    check("t5_c2_set", alu_set, 1);
    rst_n = 1'b0; #1;
    check("t5_rst_set", alu_set, 0);
    check("t5_rst_we", rf_we, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", cmd_ready, 1);
    check("t5_rst_latched", {rf_wa, alu_op_sel, alu_scalar_sel, alu_scalar}, 0);
    check_perf("t5_rst", 0, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("t5_post%0d_we", i), rf_we, 0);
      check($sformatf("t5_post%0d_busy", i), busy, 0);
      check($sformatf("t5_post%0d_done", i), done, 0);
    end
    alu_en = 1'b0;
    check_perf("t5_post", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/vector_op_sequencer.md
# vector_op_sequencer

Single-issue controller that sequences one vector ALU operation at a time for `vector_element_alu`. It accepts a command over a valid/ready handshake, reads source vectors from the external vector register file, and drives the ALU op select, scalar select and `set` strobe. It then waits for the ALU result register's `en` and writes the result back to the register file. It sits between the host command interface (Python HAL bridge) and the ALU/register-file pair.

## Interface
Parameters:
- `BITS`, 8: element width; width of the scalar operand
- `REG_AW`, 3: vector register file address width (2**REG_AW registers)
- `WAIT_MAX`, 15: maximum cycles spent in WB waiting for `alu_en` before error

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_op`  in  3  ALU op code (000 add … 111 not)
- `cmd_dst`, `cmd_src_a`, `cmd_src_b`  in  REG_AW each  destination and source register numbers
- `cmd_scalar_sel`  in  1  use `cmd_scalar` in place of B
- `cmd_scalar`  in  BITS  scalar operand
- `rf_re`  out  1  register file read strobe; read data valid on the following cycle
- `rf_ra_addr`, `rf_rb_addr`  out  REG_AW  read addresses
- `alu_op_sel`  out  3  to ALU `op_sel`
- `alu_scalar_sel`  out  1  to ALU `scalar_sel`
- `alu_scalar`  out  BITS  to ALU `scalar`
- `alu_set`  out  1  to ALU `set`; one-cycle capture strobe
- `alu_en`  in  1  ALU result register valid
- `rf_we`  out  1  write-back strobe
- `rf_wa`  out  REG_AW  write-back address
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on successful write-back
- `err`  out  1  sticky timeout flag
- `perf_ops`  out  32  completed operations (see Configuration)
- `perf_busy`  out  32  cycles with `busy`=1 (see Configuration)

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch all `cmd_*` fields, clear `err`, and go to READ.
- READ:
  - `rf_re`=1 with the latched source addresses for exactly one cycle.
  - Go to EXEC.
- EXEC:
  - `alu_set`=1 for exactly one cycle.
  - Go to WB.
  - Clear the wait counter.
- WB, when `alu_en`=1:
  - Assert `rf_we`=1 and `rf_wa`=latched dst, with `done`=1 in the same cycle.
  - Go to IDLE.
- WB, when `alu_en`=0:
  - Increment the wait counter.
  - When the counter reaches WAIT_MAX: set `err`=1, return to IDLE, no write.
- Between commands, `alu_op_sel`, `alu_scalar_sel` and `alu_scalar` hold the latched values; they are stable from READ through WB.
- Op 111 (~A) still issues the B read; B is ignored by the ALU.
- With `scalar_sel`=1, `rf_rb_addr` still drives the latched src_b; the value is unused.
- `cmd_ready`=0 in every state except IDLE, so the sequencer never holds more than one command.
- Commands with dst equal to a source register are legal: the read completes before the write.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `rf_re`, `alu_set`, `rf_we`, `done`, `err`, `busy`=0; all address, op and scalar outputs 0; perf counters 0.
- Reset mid-operation: immediate return to IDLE, no `rf_we`, and any latched command is discarded.
- Latency, with handshake in cycle 0 and `alu_en` returned promptly:
  - `rf_re` in cycle 1.
  - `alu_set` in cycle 2.
  - `rf_we`/`done` in cycle 3.
  - `cmd_ready` again in cycle 4.
- Peak throughput: one op per 4 cycles.
- Timeout: `err` rises WAIT_MAX cycles after entering WB; `cmd_ready` returns the next cycle.
- `cmd_valid` held high continuously: a new command is accepted on each IDLE cycle.

## Configuration
- Macro: `VSEQ_PERF_CNT_EN`.
- Defined:
  - `perf_ops` increments on each `done`.
  - `perf_busy` increments on each cycle with `busy`=1.
  - Both saturate at 32'hFFFFFFFF, are reset by `rst_n`, and are not cleared by commands.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Add, dst=2, src_a=0, src_b=1, `alu_en` returned one cycle after `alu_set` -> `rf_re` @1, `alu_set` @2, `rf_we`=1 with `rf_wa`=2 and `done` @3, `cmd_ready` @4, `alu_op_sel`=000 throughout.
- Scalar multiply, op=010, `cmd_scalar_sel`=1, `cmd_scalar`=8'h05 -> `alu_scalar_sel`=1 and `alu_scalar`=05 stable from READ to WB; one write-back.
- Two back-to-back commands with `cmd_valid` held high -> accepts in cycles 0 and 4, `done` pulses in cycles 3 and 7, `perf_ops`=2 (macro on).
- `alu_en` held 0 -> `err`=1 after 15 WB cycles, no `rf_we`; the next accepted command clears `err`.
- `rst_n` asserted during EXEC -> all strobes 0 immediately, state IDLE, no write-back after release.
- Macro off -> `perf_ops`=`perf_busy`=0 after any traffic.
